// File: rtl/dmux_stream.sv
// dmux_stream
//   Routes a WIDTH-bit valid/ready packet stream to one of CHANNELS = 2**SEL_W
//   output channels through a single registered output stage. The destination
//   is taken from sel on the first beat of a packet and held until the beat
//   carrying in_last is accepted. Unselected lanes always read zero.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   in_data    in   [WIDTH-1:0] input beat data
//   in_valid   in   input beat present
//   in_last    in   input beat is the final beat of its packet
//   in_ready   out  block accepts a beat this cycle (combinational)
//   sel        in   [SEL_W-1:0] destination channel, sampled on first beat
//   out_data   out  [CHANNELS*WIDTH-1:0] lane k = bits [k*WIDTH +: WIDTH]
//   out_valid  out  [CHANNELS-1:0] one-hot (or zero) valid per channel
//   out_last   out  [CHANNELS-1:0] last flag per channel
//   out_ready  in   [CHANNELS-1:0] per-channel consumer ready
//   busy       out  1 while a packet is locked (FSM state == LOCKED)
//
// Handshake: a beat moves across an interface in any cycle where its valid
// and ready are both high. in_ready depends only on reset, the output
// register and out_ready of the channel currently held, never on in_valid.
// Once out_valid is raised it and its data hold until out_ready of that
// channel is seen high.

module dmux_stream #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2,
  localparam int CHANNELS = 2 ** SEL_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS-1:0]       out_last,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   lock_ch;
  logic [SEL_W-1:0]   cur_ch;

  logic               accept;
  logic               transfer;
  logic [SEL_W-1:0]   ch;

  logic [CHANNELS*WIDTH-1:0] load_data;
  logic [CHANNELS-1:0]       load_valid;
  logic [CHANNELS-1:0]       load_last;

  // The output register can take a new beat when it is empty or when the
  // beat it holds leaves this cycle, giving one beat per cycle at full rate.
  assign in_ready = !reset && (!(|out_valid) || out_ready[cur_ch]);
  assign accept   = in_valid && in_ready;
  assign transfer = (|out_valid) && out_ready[cur_ch];

  // Mid-packet sel changes are ignored by taking the locked channel.
  assign ch = (state == IDLE) ? sel : lock_ch;

  assign busy = (state == LOCKED);

  // Next contents of the output register for an accepted beat: only lane ch
  // carries data; every other lane and last bit is zero.
  always_comb begin
    load_data  = '0;
    load_valid = '0;
    load_last  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch == SEL_W'(k)) begin
        load_data[k*WIDTH +: WIDTH] = in_data;
        load_valid[k]               = 1'b1;
        load_last[k]                = in_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lock_ch   <= '0;
      cur_ch    <= '0;
      out_data  <= '0;
      out_valid <= '0;
      out_last  <= '0;
    end else begin
      // Output register: reload on accept (covers transfer+accept with no
      // bubble), clear on a transfer with nothing new, otherwise hold.
      if (accept) begin
        out_data  <= load_data;
        out_valid <= load_valid;
        out_last  <= load_last;
        cur_ch    <= ch;
      end else if (transfer) begin
        out_data  <= '0;
        out_valid <= '0;
        out_last  <= '0;
      end

      // Packet lock FSM.
      case (state)
        IDLE: begin
          if (accept && !in_last) begin
            state   <= LOCKED;
            lock_ch <= sel;
          end
        end
        LOCKED: begin
          if (accept && in_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmux_stream.sv
module tb_dmux_stream;

  localparam int WIDTH    = 16;
  localparam int SEL_W    = 2;
  localparam int CHANNELS = 4;

  logic                      clk;
  logic                      reset;
  logic [WIDTH-1:0]          in_data;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_last;
  logic [CHANNELS-1:0]       out_ready;
  logic                      busy;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];

  dmux_stream #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l,
                       input logic [SEL_W-1:0] s);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    sel      = s;
    #1;
  endtask

  function automatic logic [63:0] lane_vec(input int k, input logic [WIDTH-1:0] d);
    logic [63:0] v;
    v = '0;
    v[k*WIDTH +: WIDTH] = d;
    return v;
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_last   = 1'b1;
    sel       = 2'd1;
    out_ready = 4'hF;

    // 1. Reset held two cycles with in_valid high
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 4'b0000);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0);

    // 2. Single-beat packets to every channel, back to back
    for (int s = 0; s < 4; s++) begin
      drive(1, 16'hA000 + 16'(s), 1, 2'(s));
      check("single_in_ready", in_ready, 1);
      tick();
      check("single_valid", out_valid, 64'(1) << s);
      check("single_data", out_data, lane_vec(s, 16'hA000 + 16'(s)));
      check("single_last", out_last, 64'(1) << s);
      check("single_busy", busy, 0);
    end
    drive(0, 0, 0, 0);
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_data", out_data, 0);

    // 3. Three-beat packet locked to channel 2, sel wiggles ignored
    drive(1, 16'h3000, 0, 2'd2);
    tick();
    check("pkt_b0_valid", out_valid, 4'b0100);
    check("pkt_b0_data", out_data, lane_vec(2, 16'h3000));
    check("pkt_b0_busy", busy, 1);
    drive(1, 16'h3001, 0, 2'd1);
    tick();
    check("pkt_b1_valid", out_valid, 4'b0100);
    check("pkt_b1_data", out_data, lane_vec(2, 16'h3001));
    check("pkt_b1_last", out_last, 0);
    check("pkt_b1_busy", busy, 1);
    drive(1, 16'h3002, 1, 2'd3);
    tick();
    check("pkt_b2_valid", out_valid, 4'b0100);
    check("pkt_b2_data", out_data, lane_vec(2, 16'h3002));
    check("pkt_b2_last", out_last, 4'b0100);
    check("pkt_b2_busy", busy, 0);
    drive(1, 16'h3100, 1, 2'd1);
    tick();
    check("next_pkt_valid", out_valid, 4'b0010);
    check("next_pkt_data", out_data, lane_vec(1, 16'h3100));
    drive(0, 0, 0, 0);
    tick();

    // 4. Backpressure on channel 2 mid-packet; other readies stay high
    drive(1, 16'h4000, 0, 2'd2);
    tick();
    check("bp_b0_data", out_data, lane_vec(2, 16'h4000));
    out_ready = 4'b1011;
    drive(1, 16'h4001, 0, 2'd0);
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 4'b0100);
      check("bp_hold_data", out_data, lane_vec(2, 16'h4000));
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_busy", busy, 1);
    end
    out_ready = 4'hF;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    check("bp_b1_data", out_data, lane_vec(2, 16'h4001));
    check("bp_b1_valid", out_valid, 4'b0100);
    drive(1, 16'h4002, 1, 2'd0);
    tick();
    check("bp_b2_data", out_data, lane_vec(2, 16'h4002));
    check("bp_b2_last", out_last, 4'b0100);
    drive(0, 0, 0, 0);
    tick();
    check("bp_drain_valid", out_valid, 0);

    // 5. Full rate: 8 beats on channel 1, scoreboard on one-cycle delay
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'h5000 + 16'(i), (i == 7), (i == 0) ? 2'd1 : 2'(i));
      check("rate_in_ready", in_ready, 1);
      exp_q.push_back(16'h5000 + 16'(i));
      tick();
      check("rate_valid", out_valid, 4'b0010);
      if (exp_q.size() > 0)
        check("rate_data", out_data, lane_vec(1, exp_q.pop_front()));
    end
    check("rate_busy_end", busy, 0);
    drive(0, 0, 0, 0);
    tick();
    check("rate_drain_valid", out_valid, 0);
    check("rate_queue_empty", exp_q.size(), 0);

    // 6. Reset mid-packet on channel 3
    drive(1, 16'h6000, 0, 2'd3);
    tick();
    drive(1, 16'h6001, 0, 2'd0);
    tick();
    check("mid_b1_data", out_data, lane_vec(3, 16'h6001));
    check("mid_b1_busy", busy, 1);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    check("mid_rst_in_ready", in_ready, 0);
    tick();
    check("mid_rst_valid", out_valid, 4'b0000);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    reset = 1'b0;
    drive(1, 16'h6100, 1, 2'd0);
    tick();
    check("post_rst_valid", out_valid, 4'b0001);
    check("post_rst_data", out_data, lane_vec(0, 16'h6100));
    check("post_rst_busy", busy, 0);
    drive(0, 0, 0, 0);
    tick();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
